// File: rtl/line_window_buffer.sv
// line_window_buffer: keeps the last NUM_ROWS-1 video lines and, for every
// accepted pixel, presents the vertical column of NUM_ROWS pixels (current
// pixel plus the same column of each stored line) one cycle later.
// Rows that have not yet been filled in the current frame read as zero.
module line_window_buffer #(
  parameter int PIXEL_WIDTH = 10,
  parameter int MAX_COLS    = 1288,
  parameter int NUM_ROWS    = 3,
  parameter int BLOCK_RAM   = 1,
  parameter int ADDR_WIDTH  = $clog2(MAX_COLS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_valid,
  input  logic                            line_valid,
  input  logic                            dvi,
  input  logic [PIXEL_WIDTH-1:0]          datai,
  output logic                            dvo,
  output logic [NUM_ROWS*PIXEL_WIDTH-1:0] datao,
  output logic [ADDR_WIDTH-1:0]           col,
  output logic                            rows_ready,
  output logic                            overflow
);

  localparam int STORED = NUM_ROWS - 1;
  localparam int RW     = (STORED > 1) ? $clog2(STORED) : 1;
  localparam int FW     = $clog2(NUM_ROWS);
  // One extra bit so the write column can reach MAX_COLS and flag overflow.
  localparam int CW     = ADDR_WIDTH + 1;

  localparam logic [RW-1:0] LAST_ROW   = RW'(STORED - 1);
  localparam logic [FW-1:0] FILLED_MAX = FW'(STORED);
  localparam logic [CW-1:0] COL_LIMIT  = CW'(MAX_COLS);

  // Advance the circular write-row pointer.
  function automatic logic [RW-1:0] row_next(input logic [RW-1:0] r);
    return (r == LAST_ROW) ? '0 : r + 1'b1;
  endfunction

  // Saturating increment of the filled-row count.
  function automatic logic [FW-1:0] filled_inc(input logic [FW-1:0] f);
    return (f == FILLED_MAX) ? f : f + 1'b1;
  endfunction

  // Stored row holding the line k lines before the one written at row r.
  function automatic int row_of_slice(input logic [RW-1:0] r, input int k);
    int idx;
    idx = int'(r) + STORED - k;
    if (idx >= STORED) idx = idx - STORED;
    return idx;
  endfunction

  logic [CW-1:0]         wcol;
  logic [RW-1:0]         wr_row;
  logic [FW-1:0]         filled;
  logic                  lv_q;
  logic                  fv_q;
  logic                  ovf_q;

  logic                  attempt_p0;
  logic                  accept_p0;
  logic                  line_end_p0;
  logic                  frame_rise_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] col_p1;
  logic [PIXEL_WIDTH-1:0] pix_p1;
  logic [RW-1:0]         wr_row_p1;
  logic [FW-1:0]         filled_p1;
  logic [STORED*PIXEL_WIDTH-1:0] rd_p1;

  // ---- stage p0: accept decision and line/frame edge detection ----
  assign attempt_p0    = dvi & line_valid & frame_valid;
  assign accept_p0     = attempt_p0 & (wcol < COL_LIMIT);
  assign line_end_p0   = lv_q & ~line_valid & frame_valid;
  assign frame_rise_p0 = frame_valid & ~fv_q;
  assign addr_p0       = wcol[ADDR_WIDTH-1:0];

  // Write position, row rotation, fill count, edge history and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcol   <= '0;
      wr_row <= '0;
      filled <= '0;
      lv_q   <= 1'b0;
      fv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      lv_q <= line_valid;
      fv_q <= frame_valid;
      // A drop at the end of a full line wins over a new-frame clear.
      if (attempt_p0 && !accept_p0) begin
        ovf_q <= 1'b1;
      end else if (frame_rise_p0) begin
        ovf_q <= 1'b0;
      end
      if (!frame_valid) begin
        wcol   <= '0;
        wr_row <= '0;
        filled <= '0;
      end else if (line_end_p0) begin
        // An empty line leaves the stored rows exactly as they were.
        if (wcol != '0) begin
          wr_row <= row_next(wr_row);
          filled <= filled_inc(filled);
        end
        wcol <= '0;
      end else if (accept_p0) begin
        wcol <= wcol + 1'b1;
      end
    end
  end

  // ---- stage p1: registered output pixel, column and row bookkeeping ----
  // Capture the accepted pixel with the row pointer and fill state it was read under.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      col_p1    <= '0;
      pix_p1    <= '0;
      wr_row_p1 <= '0;
      filled_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        col_p1    <= addr_p0;
        pix_p1    <= datai;
        wr_row_p1 <= wr_row;
        filled_p1 <= filled;
      end
    end
  end

  for (genvar r = 0; r < STORED; r++) begin : g_row
    logic [PIXEL_WIDTH-1:0] mem [MAX_COLS];
    logic [PIXEL_WIDTH-1:0] q_p1;
    logic                   we_p0;

    assign we_p0 = accept_p0 && (wr_row == RW'(r));

    if (BLOCK_RAM != 0) begin : g_bram
      // Synchronous-read RAM: old contents are read before the same-address write.
      always_ff @(posedge clk) begin
        if (accept_p0) q_p1 <= mem[addr_p0];
        if (we_p0) mem[addr_p0] <= datai;
      end
    end else begin : g_regs
      // Register-array storage written on accepted pixels for this row.
      always_ff @(posedge clk) begin
        if (we_p0) mem[addr_p0] <= datai;
      end

      // Registered read of the old column value, matching the RAM latency.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_p1 <= '0;
        end else if (accept_p0) begin
          q_p1 <= mem[addr_p0];
        end
      end
    end

    assign rd_p1[r*PIXEL_WIDTH +: PIXEL_WIDTH] = q_p1;
  end

  // Assemble the window: slice k comes from the row k lines back, masked until filled.
  always_comb begin
    datao = '0;
    datao[PIXEL_WIDTH-1:0] = pix_p1;
    for (int k = 1; k < NUM_ROWS; k++) begin
      if (k <= int'(filled_p1)) begin
        for (int r = 0; r < STORED; r++) begin
          if (row_of_slice(wr_row_p1, k) == r) begin
            datao[k*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_p1[r*PIXEL_WIDTH +: PIXEL_WIDTH];
          end
        end
      end
    end
  end

  assign dvo        = vld_p1;
  assign col        = col_p1;
  assign rows_ready = (filled == FILLED_MAX);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: a RAM-based and a register-based instance are
// driven identically and compared against a line-history model through a
// scoreboard, plus a table of expected window values per line and hand-written
// sequences for overflow, empty lines, frame drops and mid-line reset.
module tb_line_window_buffer;
  localparam int PW = 8;
  localparam int MC = 8;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_valid = 1'b0;
  logic line_valid = 1'b0;
  logic dvi = 1'b0;
  logic [PW-1:0] datai = '0;

  logic dvo_a, dvo_b, rr_a, rr_b, ov_a, ov_b;
  logic [NR*PW-1:0] datao_a, datao_b;
  logic [2:0] col_a, col_b;

  always #5 clk = ~clk;

  line_window_buffer #(.PIXEL_WIDTH(PW), .MAX_COLS(MC), .NUM_ROWS(NR), .BLOCK_RAM(1)) dut_a (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .line_valid(line_valid),
    .dvi(dvi), .datai(datai), .dvo(dvo_a), .datao(datao_a), .col(col_a),
    .rows_ready(rr_a), .overflow(ov_a));

  line_window_buffer #(.PIXEL_WIDTH(PW), .MAX_COLS(MC), .NUM_ROWS(NR), .BLOCK_RAM(0)) dut_b (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .line_valid(line_valid),
    .dvi(dvi), .datai(datai), .dvo(dvo_b), .datao(datao_b), .col(col_b),
    .rows_ready(rr_b), .overflow(ov_b));

  typedef struct {
    logic [NR*PW-1:0] d;
    logic [2:0]       c;
  } exp_t;

  typedef struct {
    int         npix;
    bit         alt;
    logic [7:0] s1;
    logic [7:0] s2;
    bit         ready;
  } line_vec_t;

  exp_t q[2][$];
  line_vec_t tbl[4];

  int n_checks = 0;
  int n_pass = 0;

  // line-history model
  logic [PW-1:0] hist [16][MC];
  logic [PW-1:0] cur [MC];
  int m_wcol = 0;
  int m_nlines = 0;
  bit m_ov = 1'b0;
  bit m_lvp = 1'b0;
  bit m_fvp = 1'b0;

  logic [NR*PW-1:0] cap_a, cap_b;
  logic cap_rr;
  int cnt_dvo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] model_slice(input int k);
    if (m_nlines >= k) return hist[m_nlines-k][m_wcol];
    return '0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_dvo_a"}, 32'(dvo_a), 0);
    chk({tag, "_datao_a"}, 32'(datao_a), 0);
    chk({tag, "_col_a"}, 32'(col_a), 0);
    chk({tag, "_rr_a"}, 32'(rr_a), 0);
    chk({tag, "_ov_a"}, 32'(ov_a), 0);
    chk({tag, "_dvo_b"}, 32'(dvo_b), 0);
    chk({tag, "_datao_b"}, 32'(datao_b), 0);
    chk({tag, "_col_b"}, 32'(col_b), 0);
    chk({tag, "_rr_b"}, 32'(rr_b), 0);
    chk({tag, "_ov_b"}, 32'(ov_b), 0);
  endtask

  task automatic cycle(input logic fv, input logic lv, input logic dv_in, input logic [PW-1:0] d);
    exp_t e;
    bit acc;
    logic dvs[2];
    logic [NR*PW-1:0] ds[2];
    logic [2:0] cs[2];
    logic rrs[2];
    logic ovs[2];
    frame_valid = fv;
    line_valid = lv;
    dvi = dv_in;
    datai = d;
    acc = dv_in && lv && fv && (m_wcol < MC);
    if (acc) begin
      e.c = 3'(m_wcol);
      e.d = {model_slice(2), model_slice(1), d};
      q[0].push_back(e);
      q[1].push_back(e);
    end
    @(posedge clk);
    #1;
    if (fv && !m_fvp) m_ov = 1'b0;
    if (dv_in && lv && fv && m_wcol >= MC) m_ov = 1'b1;
    if (!fv) begin
      m_wcol = 0;
      m_nlines = 0;
    end else if (m_lvp && !lv) begin
      if (m_wcol != 0) begin
        for (int c = 0; c < MC; c++) hist[m_nlines][c] = cur[c];
        m_nlines++;
      end
      m_wcol = 0;
    end else if (acc) begin
      cur[m_wcol] = d;
      m_wcol++;
    end
    m_lvp = lv;
    m_fvp = fv;

    dvs = '{dvo_a, dvo_b};
    ds  = '{datao_a, datao_b};
    cs  = '{col_a, col_b};
    rrs = '{rr_a, rr_b};
    ovs = '{ov_a, ov_b};
    for (int i = 0; i < 2; i++) begin
      if (dvs[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("dvo_spurious[%0d]", i), 32'(dvs[i]), 0);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("datao[%0d]", i), 32'(ds[i]), 32'(e.d));
          chk($sformatf("col[%0d]", i), 32'(cs[i]), 32'(e.c));
        end
      end
      if (q[i].size() != 0) begin
        chk($sformatf("dvo_missing[%0d]", i), 32'(dvs[i]), 1);
        q[i].delete();
      end
      chk($sformatf("rows_ready[%0d]", i), 32'(rrs[i]), 32'(m_nlines >= NR-1));
      chk($sformatf("overflow[%0d]", i), 32'(ovs[i]), 32'(m_ov));
    end

    if (dvo_a) cnt_dvo++;
    if (dvo_a && col_a == 3'd5) begin
      cap_a = datao_a;
      cap_rr = rr_a;
    end
    if (dvo_b && col_b == 3'd5) cap_b = datao_b;
  endtask

  task automatic run_line(input int idx, input int npix, input bit alt, input logic [PW-1:0] base);
    int sent;
    int ph;
    cnt_dvo = 0;
    cap_a = 'x;
    cap_b = 'x;
    cap_rr = 1'bx;
    sent = 0;
    ph = 0;
    while (sent < npix) begin
      if (alt && ph[0]) begin
        cycle(1'b1, 1'b1, 1'b0, '0);
      end else begin
        cycle(1'b1, 1'b1, 1'b1, PW'(int'(base) + idx*16 + sent));
        sent++;
      end
      ph++;
    end
    // dvi together with the falling line_valid must be ignored
    cycle(1'b1, 1'b0, 1'b1, 8'hEE);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    chk($sformatf("dvo_count_line%0d", idx), 32'(cnt_dvo), 32'((npix < MC) ? npix : MC));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8, 1'b0, 8'h05, 8'h00, 1'b0};
    tbl[2] = '{8, 1'b0, 8'h15, 8'h05, 1'b1};
    tbl[3] = '{8, 1'b1, 8'h25, 8'h15, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);

    // frame A: 4 lines x 8 columns, table-checked at column 5
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      run_line(i, tbl[i].npix, tbl[i].alt, 8'h00);
      chk($sformatf("tbl%0d_s0", i), 32'(cap_a[7:0]), 32'(8'(i*16 + 5)));
      chk($sformatf("tbl%0d_s1", i), 32'(cap_a[15:8]), 32'(tbl[i].s1));
      chk($sformatf("tbl%0d_s2", i), 32'(cap_a[23:16]), 32'(tbl[i].s2));
      chk($sformatf("tbl%0d_ready", i), 32'(cap_rr), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_b_window", i), 32'(cap_b[23:8]), 32'({tbl[i].s2, tbl[i].s1}));
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);

    // frame B: overlong line, empty line, then a data line
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
    run_line(0, 10, 1'b0, 8'h80);
    chk("newframe_s1s2_zero", 32'(cap_a[23:8]), 0);
    chk("overflow_set_a", 32'(ov_a), 1);
    chk("overflow_set_b", 32'(ov_b), 1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    run_line(2, 8, 1'b0, 8'h80);
    chk("empty_line_s1", 32'(cap_a[15:8]), 32'h85);
    chk("empty_line_s2", 32'(cap_a[23:16]), 0);
    chk("empty_line_s1_b", 32'(cap_b[15:8]), 32'h85);
    chk("empty_line_ready", 32'(cap_rr), 0);
    chk("overflow_held", 32'(ov_a), 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, '0);
    chk("overflow_held_fv_low", 32'(ov_a), 1);
    cycle(1'b1, 1'b0, 1'b0, '0);
    chk("overflow_clear_a", 32'(ov_a), 0);
    chk("overflow_clear_b", 32'(ov_b), 0);

    // frame D: two lines, reset part way through the third
    cycle(1'b1, 1'b0, 1'b0, '0);
    run_line(0, 8, 1'b0, 8'h40);
    chk("frameD_l0_s1s2_zero", 32'(cap_a[23:8]), 0);
    run_line(1, 8, 1'b0, 8'h40);
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1, 1'b1, 8'(8'h60 + c));
    reset = 1'b1;
    line_valid = 1'b0;
    dvi = 1'b0;
    #2;
    check_zero("reset_async");
    m_wcol = 0;
    m_nlines = 0;
    m_ov = 1'b0;
    m_lvp = 1'b0;
    m_fvp = 1'b0;
    q[0].delete();
    q[1].delete();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    reset = 1'b0;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
    run_line(0, 8, 1'b0, 8'hC0);
    chk("after_reset_s0", 32'(cap_a[7:0]), 32'hC5);
    chk("after_reset_s1s2", 32'(cap_a[23:8]), 0);
    chk("after_reset_s1s2_b", 32'(cap_b[23:8]), 0);
    chk("after_reset_ready", 32'(cap_rr), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
